// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter and its post-filter stages:
// default word widths, filter order and the round/shift/saturate helpers.
package fir_pkg;

  localparam int IN_W_DEF   = 14;
  localparam int OUT_W_DEF  = 8;
  localparam int FIR_ORDER  = 4;
  // One register per tap plus the output register before the first settled word.
  localparam int WARMUP_DEF = FIR_ORDER + 2;

  function automatic logic [32:0] roundShift(input logic [31:0] word,
                                             input int unsigned shift);
    logic [32:0] sum;
    sum = {1'b0, word} + (33'd1 << (shift - 1));
    return sum >> shift;
  endfunction

  function automatic logic satFlag(input logic [31:0] word,
                                   input int unsigned shift,
                                   input int unsigned outW);
    return roundShift(word, shift) > ((33'd1 << outW) - 33'd1);
  endfunction

  function automatic logic [31:0] roundShiftSat(input logic [31:0] word,
                                                input int unsigned shift,
                                                input int unsigned outW);
    logic [32:0] r;
    logic [32:0] maxVal;
    r      = roundShift(word, shift);
    maxVal = (33'd1 << outW) - 33'd1;
    return (r > maxVal) ? maxVal[31:0] : r[31:0];
  endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Small synchronous first-word-fall-through FIFO; dout always shows the head entry.
module fir_out_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             doPush;
  logic             doPop;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign doPop  = pop && !empty;
  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign doPush = push && (!full || doPop);
  assign dout   = mem_q[rdPtr_q];
  assign count  = count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= din;
        wrPtr_q        <= wrPtr_q + 1'b1;
      end
      if (doPop) rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fir_out_conditioner.sv
// Post-filter conditioner: drops pipeline-fill words, decimates, rounds and
// saturates to a narrow sample, and queues results behind valid/ready.
module fir_out_conditioner
  import fir_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int SHIFT  = 6,
  parameter int WARMUP = WARMUP_DEF,
  parameter int DECIM  = 1,
  parameter int DEPTH  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [IN_W-1:0]        fir_in,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  output logic                   sat_pulse,
  output logic                   ovf_flag,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int WARM_W = $clog2(WARMUP + 2);

  logic [WARM_W-1:0] warmCnt_q, warmCnt_d;
  logic [3:0]        phase_q, phase_d;
  logic [OUT_W-1:0]  stage1Data_q, stage1Data_d;
  logic              stage1Sat_q, stage1Sat_d;
  logic              stage1Push_q, stage1Push_d;
  logic              ovf_q, ovf_d;
  logic              eligible;
  logic              pop;
  logic              fifoFull;
  logic              fifoEmpty;

  assign eligible = (warmCnt_q == WARM_W'(WARMUP));
  assign pop      = out_ready && !fifoEmpty;

  always_comb begin
    warmCnt_d    = warmCnt_q;
    phase_d      = phase_q;
    stage1Data_d = OUT_W'(roundShiftSat(32'(fir_in), SHIFT, OUT_W));
    stage1Sat_d  = satFlag(32'(fir_in), SHIFT, OUT_W);
    stage1Push_d = eligible && (phase_q == 4'd0);
    ovf_d        = ovf_q | (stage1Push_q && fifoFull && !pop);
    if (!eligible) warmCnt_d = warmCnt_q + 1'b1;
    if (eligible) phase_d = (phase_q == 4'(DECIM - 1)) ? 4'd0 : phase_q + 4'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      warmCnt_q    <= '0;
      phase_q      <= '0;
      stage1Data_q <= '0;
      stage1Sat_q  <= 1'b0;
      stage1Push_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      warmCnt_q    <= warmCnt_d;
      phase_q      <= phase_d;
      stage1Data_q <= stage1Data_d;
      stage1Sat_q  <= stage1Sat_d;
      stage1Push_q <= stage1Push_d;
      ovf_q        <= ovf_d;
    end
  end

  fir_out_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (stage1Push_q),
    .din   (stage1Data_q),
    .pop   (pop),
    .dout  (out_data),
    .count (fifo_count),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  assign out_valid = !fifoEmpty;
  assign sat_pulse = stage1Sat_q && stage1Push_q;
  assign ovf_flag  = ovf_q;

endmodule
